parallel_send: RTL and testbench

Pattern transmitter for the 16-bit parallel link test path. On a START request it sends a framed burst of pseudo-random words to the serializer side: a one-cycle INIT marker, then WORDS data words from the `lfsr32x2` sequence. The sequence is seeded with 16'h0001 and continues across bursts until CLR. Optional per-word bit-flip injection and sent/injected counters let the far-end checker's error and receive counts be verified exactly.

---
 rtl/parallel_send.sv | 155 +++++++++++++++
 tb/tb_parallel_send.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/parallel_send.sv
// Framed pseudo-random pattern transmitter: INIT marker, then WORDS lfsr32x2 words,
// with one-shot bit-flip injection and pushed-word / flipped-bit counters.
module parallel_send #(
    parameter int WORDS = 1024,
    parameter int CW    = 11
) (
    input  logic        CLK,
    input  logic        RSTX,
    input  logic        CLR,
    input  logic        START,
    input  logic        DORDY,
    input  logic        ERR_INJ,
    input  logic [15:0] ERR_MASK,
    output logic        INIT,
    output logic        DOPUSH,
    output logic [15:0] DOUT,
    output logic        BUSY,
    output logic [57:0] SEND_CNT,
    output logic [63:0] INJ_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] remain;
    logic [15:0]   lfsr;
    logic [15:0]   inj_mask;
    logic          inj_pend;
    logic [57:0]   send_cnt;
    logic [63:0]   inj_cnt;
    logic [4:0]    inj_bits;
    logic [64:0]   inj_sum;

    // lfsr32x2: two shifts of x^16+x^14+x^13+x^11+1, feedback into bit 0.
    function automatic logic [15:0] lfsr32x2(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 2; i++) begin
            r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
        end
        return r;
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    // State register
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state <= ST_IDLE;
        end else if (CLR) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (START) state_nx = ST_INIT;
            ST_INIT: state_nx = ST_SEND;
            ST_SEND: if (DORDY && remain == CW'(1)) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        INIT   = 1'b0;
        BUSY   = 1'b0;
        DOPUSH = 1'b0;
        DOUT   = 16'h0000;
        case (state)
            ST_INIT: begin
                INIT = 1'b1;
                BUSY = 1'b1;
            end
            ST_SEND: begin
                BUSY   = 1'b1;
                DOPUSH = DORDY;
                if (DORDY) DOUT = lfsr ^ (inj_pend ? inj_mask : 16'h0000);
            end
            default: ;
        endcase
    end

    assign inj_bits = popcount16(inj_mask);
    assign inj_sum  = {1'b0, inj_cnt} + {60'd0, inj_bits};

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            remain <= '0;
            lfsr   <= 16'h0001;
        end else if (CLR) begin
            remain <= '0;
            lfsr   <= 16'h0001;
        end else begin
            if (state == ST_IDLE && START) begin
                remain <= CW'(WORDS);
            end else if (DOPUSH && remain != '0) begin
                remain <= remain - CW'(1);
            end
            if (DOPUSH) lfsr <= lfsr32x2(lfsr);
        end
    end

    // A new request in the same cycle as a consuming push arms the following word.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            inj_pend <= 1'b0;
            inj_mask <= 16'h0000;
        end else if (CLR) begin
            inj_pend <= 1'b0;
            inj_mask <= 16'h0000;
        end else if (ERR_INJ) begin
            inj_pend <= 1'b1;
            inj_mask <= ERR_MASK;
        end else if (DOPUSH) begin
            inj_pend <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            send_cnt <= '0;
            inj_cnt  <= '0;
        end else if (CLR) begin
            send_cnt <= '0;
            inj_cnt  <= '0;
        end else begin
            if (DOPUSH) send_cnt <= send_cnt + 58'd1;
            // Carry out of the 65-bit sum pins the count at all ones.
            if (DOPUSH && inj_pend) begin
                inj_cnt <= inj_sum[64] ? {64{1'b1}} : inj_sum[63:0];
            end
        end
    end

    assign SEND_CNT = send_cnt;
    assign INJ_CNT  = inj_cnt;

endmodule

// File: tb/tb_parallel_send.sv
// Directed/randomized bench for parallel_send against a word-level reference model.
module tb_parallel_send;

    localparam int WORDS = 1024;

    logic        CLK = 1'b0;
    logic        RSTX = 1'b0;
    logic        CLR = 1'b0;
    logic        START = 1'b0;
    logic        DORDY = 1'b0;
    logic        ERR_INJ = 1'b0;
    logic [15:0] ERR_MASK = 16'h0000;
    logic        INIT;
    logic        DOPUSH;
    logic [15:0] DOUT;
    logic        BUSY;
    logic [57:0] SEND_CNT;
    logic [63:0] INJ_CNT;

    parallel_send #(.WORDS(WORDS), .CW(11)) dut (
        .CLK(CLK), .RSTX(RSTX), .CLR(CLR), .START(START), .DORDY(DORDY),
        .ERR_INJ(ERR_INJ), .ERR_MASK(ERR_MASK), .INIT(INIT), .DOPUSH(DOPUSH),
        .DOUT(DOUT), .BUSY(BUSY), .SEND_CNT(SEND_CNT), .INJ_CNT(INJ_CNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] m_lfsr;
    logic [15:0] m_mask;
    bit          m_pend;
    logic [57:0] m_send;
    logic [63:0] m_inj;
    logic [15:0] burst_start_lfsr;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    function automatic logic [15:0] lfsr_ref(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        repeat (2) r = {r[14:0], ^(r & 16'hB400)};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_lfsr = 16'h0001;
        m_mask = 16'h0000;
        m_pend = 1'b0;
        m_send = '0;
        m_inj  = '0;
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance the model, move to next cycle.
    task automatic step(input bit e_init, input bit e_send, input bit d, input bit s,
                        input bit inj, input logic [15:0] mask, output bit pushed);
        logic [15:0] exp_dout;
        int unsigned pc;
        START = s; DORDY = d; ERR_INJ = inj; ERR_MASK = mask; CLR = 1'b0;
        #1;
        pushed   = e_send && d;
        exp_dout = pushed ? (m_lfsr ^ (m_pend ? m_mask : 16'h0000)) : 16'h0000;
        chk("INIT", INIT, e_init);
        chk("BUSY", BUSY, e_init | e_send);
        chk("DOPUSH", DOPUSH, pushed);
        chk("DOUT", DOUT, exp_dout);
        chk("SEND_CNT", SEND_CNT, m_send);
        chk("INJ_CNT", INJ_CNT, m_inj);
        if (pushed) begin
            got_q.push_back(DOUT);
            if (m_pend) begin
                pc = $countones(m_mask);
                if (m_inj > (~64'd0 - 64'(pc))) m_inj = ~64'd0;
                else m_inj = m_inj + 64'(pc);
                m_pend = 1'b0;
            end
            m_lfsr = lfsr_ref(m_lfsr);
            m_send = m_send + 58'd1;
        end
        if (inj) begin
            m_pend = 1'b1;
            m_mask = mask;
        end
        @(posedge CLK); #1;
    endtask

    // inj_word: 1-based word to corrupt (0 = none); abort_at: CLR after that many pushes (0 = none).
    task automatic run_burst(input bit stall, input int inj_word, input logic [15:0] mask,
                             input bit hold_start, input int abort_at);
        int words;
        int budget;
        bit p;
        bit d;
        bit inj;
        bit inj_done;
        words = 0; budget = 0; inj_done = 0;
        got_q.delete();
        exp_q.delete();
        burst_start_lfsr = m_lfsr;
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, p);
        step(1'b1, 1'b0, bit'($urandom_range(0, 1)), hold_start, inj_word == 1, mask, p);
        if (inj_word == 1) inj_done = 1;
        while (words < WORDS && budget < 8 * WORDS) begin
            if (abort_at > 0 && words == abort_at) break;
            d = stall ? bit'($urandom_range(0, 1)) : 1'b1;
            inj = 1'b0;
            if (!inj_done && inj_word > 1 && words == inj_word - 2) begin
                d = 1'b1; inj = 1'b1; inj_done = 1;
            end
            step(1'b0, 1'b1, d, hold_start, inj, mask, p);
            if (p) words++;
            budget++;
        end
        chk("burst_budget", 64'(budget < 8 * WORDS), 64'd1);
        if (abort_at > 0 && words == abort_at) begin
            CLR = 1'b1; DORDY = 1'b1; START = hold_start;
            @(posedge CLK); #1;
            model_clear();
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, p);
        end else begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, p);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, p);
            chk("burst_len", 64'(got_q.size()), 64'(WORDS));
        end
        begin
            logic [15:0] v;
            v = burst_start_lfsr;
            for (int i = 0; i < got_q.size(); i++) begin
                exp_q.push_back(v);
                v = lfsr_ref(v);
            end
        end
    endtask

    initial begin
        logic [15:0] after1024;
        model_clear();
        RSTX = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_INIT", INIT, 0);
        chk("rst_BUSY", BUSY, 0);
        chk("rst_DOPUSH", DOPUSH, 0);
        chk("rst_DOUT", DOUT, 0);
        chk("rst_SEND_CNT", SEND_CNT, 0);
        chk("rst_INJ_CNT", INJ_CNT, 0);
        RSTX = 1'b1;
        @(posedge CLK); #1;

        // Plain burst from reset
        run_burst(1'b0, 0, 16'h0000, 1'b0, 0);
        chk("b1_word1", got_q[0], 16'h0001);
        chk("b1_word2", got_q[1], 16'h0004);
        chk("b1_send_cnt", SEND_CNT, 64'd1024);
        chk("b1_busy_after", BUSY, 0);

        // Second burst continues the sequence
        after1024 = 16'h0001;
        for (int i = 0; i < WORDS; i++) after1024 = lfsr_ref(after1024);
        run_burst(1'b0, 0, 16'h0000, 1'b0, 0);
        chk("b2_word1", got_q[0], after1024);
        chk("b2_send_cnt", SEND_CNT, 64'd2048);

        // Stalled burst with injection into word 5
        run_burst(1'b1, 5, 16'h8001, 1'b0, 0);
        chk("inj_w4_clean", got_q[3], exp_q[3]);
        chk("inj_w5_flip", got_q[4], exp_q[4] ^ 16'h8001);
        chk("inj_w6_clean", got_q[5], exp_q[5]);
        chk("inj_w_last", got_q[WORDS-1], exp_q[WORDS-1]);
        chk("inj_cnt_2", INJ_CNT, 64'd2);
        chk("b3_send_cnt", SEND_CNT, 64'd3072);

        // Full mask armed during INIT hits word 1
        run_burst(1'b1, 1, 16'hFFFF, 1'b0, 0);
        chk("ffff_w1", got_q[0], exp_q[0] ^ 16'hFFFF);
        chk("ffff_w2", got_q[1], exp_q[1]);
        chk("inj_cnt_18", INJ_CNT, 64'd18);

        // Saturation
        force dut.inj_cnt = ~64'd5;
        #1;
        release dut.inj_cnt;
        m_inj = ~64'd5;
        @(posedge CLK); #1;
        chk("forced_inj_cnt", INJ_CNT, ~64'd5);
        run_burst(1'b0, 3, 16'hFFFF, 1'b0, 0);
        chk("inj_sat", INJ_CNT, ~64'd0);
        run_burst(1'b1, 2, 16'h0101, 1'b0, 0);
        chk("inj_sat_hold", INJ_CNT, ~64'd0);

        // CLR mid-burst, then restart with START held high throughout
        run_burst(1'b0, 0, 16'h0000, 1'b0, 300);
        chk("clr_send_cnt", SEND_CNT, 64'd0);
        chk("clr_inj_cnt", INJ_CNT, 64'd0);
        chk("clr_busy", BUSY, 0);
        run_burst(1'b1, 0, 16'h0000, 1'b1, 0);
        chk("restart_word1", got_q[0], 16'h0001);
        chk("restart_send_cnt", SEND_CNT, 64'd1024);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
